// File: rtl/br_update_queue_pkg.sv
// Shared fetch-unit types for the branch update path: PHT write entry and
// the saturating-counter rule, also reusable by the predictor.
package br_update_queue_pkg;
  localparam int BR_UPDATE_QUEUE_DEPTH = 8;
  localparam int BRQ_ENQ_WIDTH         = 2;
  localparam int BRQ_INDEX_BITS        = 9;
  localparam int BRQ_HIST_BITS         = 2;
  localparam int BRQ_CTR_BITS          = 2;
  localparam int BRQ_WR_PORTS          = 2;

  typedef logic [BRQ_INDEX_BITS-1:0] brq_index_t;
  typedef logic [BRQ_HIST_BITS-1:0]  brq_sel_t;
  typedef logic [BRQ_CTR_BITS-1:0]   brq_ctr_t;

  typedef struct packed {
    brq_index_t index;
    brq_sel_t   sel;
    brq_ctr_t   ctr;
  } br_update_entry_t;

  function automatic brq_ctr_t sat_ctr_update(input brq_ctr_t ctr, input logic taken);
    if (taken) return (ctr == '1) ? ctr : ctr + brq_ctr_t'(1);
    return (ctr == '0) ? ctr : ctr - brq_ctr_t'(1);
  endfunction
endpackage

// File: rtl/br_update_queue_if.sv
// Execute-side enqueue lanes plus PHT write ports and queue status.
interface br_update_queue_if
  import br_update_queue_pkg::*;
#(
  parameter int DEPTH     = BR_UPDATE_QUEUE_DEPTH,
  parameter int ENQ_WIDTH = BRQ_ENQ_WIDTH
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [ENQ_WIDTH-1:0]               enq_valid;
  brq_index_t [ENQ_WIDTH-1:0]         enq_index;
  brq_sel_t   [ENQ_WIDTH-1:0]         enq_hist;
  brq_ctr_t   [ENQ_WIDTH-1:0]         enq_ctr;
  logic [ENQ_WIDTH-1:0]               enq_taken;
  logic                               hold;
  logic                               flush;
  logic [BRQ_WR_PORTS-1:0]            wr_en;
  brq_index_t [BRQ_WR_PORTS-1:0]      wr_index;
  brq_sel_t   [BRQ_WR_PORTS-1:0]      wr_sel;
  brq_ctr_t   [BRQ_WR_PORTS-1:0]      wr_ctr;
  logic [OCC_W-1:0]                   occupancy;
  logic                               almost_full;
  logic [15:0]                        drop_count;

  modport master (
    output enq_valid, enq_index, enq_hist, enq_ctr, enq_taken, hold, flush,
    input  wr_en, wr_index, wr_sel, wr_ctr, occupancy, almost_full, drop_count
  );
  modport slave (
    input  enq_valid, enq_index, enq_hist, enq_ctr, enq_taken, hold, flush,
    output wr_en, wr_index, wr_sel, wr_ctr, occupancy, almost_full, drop_count
  );
endinterface

// File: rtl/br_update_queue_ram.sv
// Queue storage: DEPTH entries, NWR write ports, two combinational read ports.
module br_update_queue_ram
  import br_update_queue_pkg::*;
#(
  parameter int DEPTH = BR_UPDATE_QUEUE_DEPTH,
  parameter int NWR   = BRQ_ENQ_WIDTH
)(
  input  logic                                 clk,
  input  logic [NWR-1:0]                       i_we,
  input  logic [NWR-1:0][$clog2(DEPTH)-1:0]    i_waddr,
  input  br_update_entry_t [NWR-1:0]           i_wdata,
  input  logic [1:0][$clog2(DEPTH)-1:0]        i_raddr,
  output br_update_entry_t [1:0]               o_rdata
);
  br_update_entry_t r_mem [DEPTH];

  // Write addresses are always distinct, so port order does not matter.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NWR; k++) begin
      if (i_we[k]) r_mem[i_waddr[k]] <= i_wdata[k];
    end
  end

  assign o_rdata[0] = r_mem[i_raddr[0]];
  assign o_rdata[1] = r_mem[i_raddr[1]];
endmodule

// File: rtl/br_update_queue.sv
// Branch-resolution queue feeding bank-conflict-free PHT counter writes,
// up to two per cycle, with lane-ordered enqueue and saturating drop count.
module br_update_queue
  import br_update_queue_pkg::*;
#(
  parameter int DEPTH     = BR_UPDATE_QUEUE_DEPTH,
  parameter int ENQ_WIDTH = BRQ_ENQ_WIDTH
)(
  input  logic              clk,
  input  logic              rst,
  br_update_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  ptr_t                         r_head, r_tail;
  cnt_t                         r_occ;
  logic [15:0]                  r_drop;
  logic [1:0]                   r_wr_en;
  br_update_entry_t [1:0]       r_wr;

  ptr_t [1:0]                   w_raddr;
  br_update_entry_t [1:0]       w_rdata;
  logic [ENQ_WIDTH-1:0]         w_we;
  ptr_t [ENQ_WIDTH-1:0]         w_waddr;
  br_update_entry_t [ENQ_WIDTH-1:0] w_wdata;
  br_update_entry_t [ENQ_WIDTH-1:0] w_lane;
  logic                         w_deq0, w_deq1;
  cnt_t                         w_deq_n, w_free, w_acc, w_drops_n;
  logic [16:0]                  w_drop_sum;
  logic [15:0]                  w_drop_nxt;

  genvar g;
  generate
    for (g = 0; g < ENQ_WIDTH; g++) begin : g_lane
      assign w_lane[g] = '{index: bus.enq_index[g], sel: bus.enq_hist[g],
                           ctr: sat_ctr_update(bus.enq_ctr[g], bus.enq_taken[g])};
    end
  endgenerate

  // Port 1 only pairs with port 0 when the two entries hit different banks.
  assign w_raddr[0] = r_head;
  assign w_raddr[1] = r_head + ptr_t'(1);
  assign w_deq0     = !bus.flush && !bus.hold && (r_occ != '0);
  assign w_deq1     = w_deq0 && (r_occ >= cnt_t'(2)) &&
                      (w_rdata[0].index[0] != w_rdata[1].index[0]);
  assign w_deq_n    = cnt_t'(w_deq0) + cnt_t'(w_deq1);
  assign w_free     = cnt_t'(DEPTH) - r_occ + w_deq_n;

  always_comb begin
    w_we      = '0;
    w_waddr   = '0;
    w_wdata   = '0;
    w_acc     = '0;
    w_drops_n = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (bus.enq_valid[i] && !bus.flush) begin
        if (w_acc < w_free) begin
          w_we[i]    = 1'b1;
          w_waddr[i] = r_tail + w_acc[PTR_W-1:0];
          w_wdata[i] = w_lane[i];
          w_acc      = w_acc + cnt_t'(1);
        end else begin
          w_drops_n  = w_drops_n + cnt_t'(1);
        end
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_drops_n);
  assign w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_drop  <= '0;
      r_wr_en <= '0;
      r_wr    <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_wr_en <= '0;
      r_wr    <= '0;
    end else begin
      r_head  <= r_head + w_deq_n[PTR_W-1:0];
      r_tail  <= r_tail + w_acc[PTR_W-1:0];
      r_occ   <= r_occ + w_acc - w_deq_n;
      r_drop  <= w_drop_nxt;
      r_wr_en <= {w_deq1, w_deq0};
      r_wr[0] <= w_deq0 ? w_rdata[0] : '0;
      r_wr[1] <= w_deq1 ? w_rdata[1] : '0;
    end
  end

  br_update_queue_ram #(.DEPTH(DEPTH), .NWR(ENQ_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  generate
    for (g = 0; g < BRQ_WR_PORTS; g++) begin : g_wr
      assign bus.wr_index[g] = r_wr[g].index;
      assign bus.wr_sel[g]   = r_wr[g].sel;
      assign bus.wr_ctr[g]   = r_wr[g].ctr;
    end
  endgenerate

  assign bus.wr_en       = r_wr_en;
  assign bus.occupancy   = r_occ;
  assign bus.almost_full = r_occ > cnt_t'(DEPTH - ENQ_WIDTH);
  assign bus.drop_count  = r_drop;
endmodule

// File: tb/tb_br_update_queue.sv
// Directed and randomized bench for br_update_queue against a queue-based model.
module tb_br_update_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_update_queue_if #(.DEPTH(DEPTH), .ENQ_WIDTH(2)) bus();
  br_update_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int idx; int sel; int ctr; } ment_t;
  ment_t    mq[$];
  int       m_drop;
  bit [1:0] e_en;
  ment_t    e_out[2];
  int       checks   = 0;
  int       failures = 0;
  bit       rhold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input int i0, input int h0, input int c0, input bit t0,
                       input bit v1, input int i1, input int h1, input int c1, input bit t1);
    bus.enq_valid    = {v1, v0};
    bus.enq_index[0] = 9'(i0);  bus.enq_index[1] = 9'(i1);
    bus.enq_hist[0]  = 2'(h0);  bus.enq_hist[1]  = 2'(h1);
    bus.enq_ctr[0]   = 2'(c0);  bus.enq_ctr[1]   = 2'(c1);
    bus.enq_taken    = {t1, t0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference behaviour: pop up to two from the front (second only on a
  // different bank), then append valid lanes in order while room remains.
  task automatic model_step();
    ment_t p0, e;
    e_en = 2'b00;
    e_out[0] = '{0, 0, 0};
    e_out[1] = '{0, 0, 0};
    if (bus.flush) begin
      mq.delete();
      return;
    end
    if (!bus.hold && mq.size() > 0) begin
      p0 = mq.pop_front();
      e_en[0] = 1'b1;
      e_out[0] = p0;
      if (mq.size() > 0 && (mq[0].idx % 2) != (p0.idx % 2)) begin
        e_out[1] = mq.pop_front();
        e_en[1] = 1'b1;
      end
    end
    for (int l = 0; l < 2; l++) begin
      if (bus.enq_valid[l]) begin
        if (mq.size() < DEPTH) begin
          e.idx = int'(bus.enq_index[l]);
          e.sel = int'(bus.enq_hist[l]);
          if (bus.enq_taken[l]) e.ctr = (int'(bus.enq_ctr[l]) + 1 > 3) ? 3 : int'(bus.enq_ctr[l]) + 1;
          else                  e.ctr = (int'(bus.enq_ctr[l]) - 1 < 0) ? 0 : int'(bus.enq_ctr[l]) - 1;
          mq.push_back(e);
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", 32'(bus.wr_en), 32'(e_en));
    for (int p = 0; p < 2; p++) begin
      if (e_en[p]) begin
        chk($sformatf("wr_index%0d", p), 32'(bus.wr_index[p]), e_out[p].idx);
        chk($sformatf("wr_sel%0d", p),   32'(bus.wr_sel[p]),   e_out[p].sel);
        chk($sformatf("wr_ctr%0d", p),   32'(bus.wr_ctr[p]),   e_out[p].ctr);
      end
    end
    chk("occupancy",   32'(bus.occupancy),   mq.size());
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() > DEPTH - 2));
    chk("drop_count",  32'(bus.drop_count),  m_drop);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_drop = 0;
    e_en = 2'b00;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    idle();
    #12;
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_index", 32'({bus.wr_index[1], bus.wr_index[0]}), 0);
    chk("rst_wr_sel_ctr", 32'({bus.wr_sel, bus.wr_ctr}), 0);
    chk("rst_occupancy", 32'(bus.occupancy), 0);
    chk("rst_almost_full", 32'(bus.almost_full), 0);
    chk("rst_drop_count", 32'(bus.drop_count), 0);
    rst = 1'b0;

    // single enqueue, two-cycle latency
    drive(1, 5, 2, 1, 1, 0, 0, 0, 0, 0);
    cycle();
    chk("single_occ1", 32'(bus.occupancy), 1);
    idle();
    cycle();
    chk("single_en", 32'(bus.wr_en), 1);
    chk("single_idx", 32'(bus.wr_index[0]), 5);
    chk("single_sel", 32'(bus.wr_sel[0]), 2);
    chk("single_ctr", 32'(bus.wr_ctr[0]), 2);
    chk("single_occ0", 32'(bus.occupancy), 0);

    // counter saturation at both ends
    drive(1, 2, 1, 3, 1, 1, 3, 0, 0, 0);
    cycle();
    idle();
    cycle();
    chk("sat_en", 32'(bus.wr_en), 3);
    chk("sat_hi", 32'(bus.wr_ctr[0]), 3);
    chk("sat_lo", 32'(bus.wr_ctr[1]), 0);

    // same bank serialises, different banks pair up
    drive(1, 4, 0, 1, 0, 1, 6, 1, 2, 1);
    cycle();
    idle();
    cycle();
    chk("bank_a_en", 32'(bus.wr_en), 1);
    chk("bank_a_idx", 32'(bus.wr_index[0]), 4);
    cycle();
    chk("bank_b_en", 32'(bus.wr_en), 1);
    chk("bank_b_idx", 32'(bus.wr_index[0]), 6);
    drive(1, 4, 3, 2, 1, 1, 7, 2, 1, 0);
    cycle();
    idle();
    cycle();
    chk("pair_en", 32'(bus.wr_en), 3);
    chk("pair_idx0", 32'(bus.wr_index[0]), 4);
    chk("pair_idx1", 32'(bus.wr_index[1]), 7);
    cycle();

    // overflow while held, then ordered drain
    bus.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 10 + 2*k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            1, 11 + 2*k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      cycle();
    end
    chk("ovf_occ", 32'(bus.occupancy), 8);
    chk("ovf_drop", 32'(bus.drop_count), 2);
    chk("ovf_af", 32'(bus.almost_full), 1);
    bus.hold = 1'b0;
    idle();
    cycle();
    chk("drain_idx0", 32'(bus.wr_index[0]), 10);
    chk("drain_idx1", 32'(bus.wr_index[1]), 11);
    for (int k = 0; k < 5; k++) cycle();

    // flush with queued entries and valid lanes
    bus.hold = 1'b1;
    drive(1, 20, 0, 1, 1, 1, 21, 1, 2, 0);
    cycle();
    drive(1, 22, 2, 0, 1, 0, 0, 0, 0, 0);
    cycle();
    chk("pre_flush_occ", 32'(bus.occupancy), 3);
    bus.hold = 1'b0;
    bus.flush = 1'b1;
    drive(1, 30, 0, 0, 1, 1, 31, 0, 0, 1);
    cycle();
    chk("flush_occ", 32'(bus.occupancy), 0);
    chk("flush_en", 32'(bus.wr_en), 0);
    chk("flush_drop", 32'(bus.drop_count), 2);
    bus.flush = 1'b0;
    idle();
    cycle();

    // randomized traffic with bursts of hold and rare flush
    rhold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) rhold = ~rhold;
      bus.hold  = rhold;
      bus.flush = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      cycle();
    end

    // async reset in the middle of a drain
    bus.flush = 1'b0;
    bus.hold  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 40 + 2*k, 1, 2, 1, 1, 41 + 2*k, 2, 1, 0);
      cycle();
    end
    bus.hold = 1'b0;
    idle();
    cycle();
    chk("drain_active", 32'(bus.wr_en), 3);
    #3;
    rst = 1'b1;
    #1;
    mq.delete();
    m_drop = 0;
    chk("arst_wr_en", 32'(bus.wr_en), 0);
    chk("arst_occ", 32'(bus.occupancy), 0);
    chk("arst_drop", 32'(bus.drop_count), 0);
    chk("arst_idx", 32'({bus.wr_index[1], bus.wr_index[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    e_en = 2'b00;
    drive(1, 9, 3, 2, 0, 0, 0, 0, 0, 0);
    cycle();
    idle();
    cycle();
    chk("post_rst_idx", 32'(bus.wr_index[0]), 9);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/br_update_queue.md
Name: br_update_queue

Overview:
- Buffers resolved conditional-branch results from the integer issue lanes.
- Converts them into per-address PHT counter writes for the PAp predictor, at most two per cycle.
- Writes are bank-conflict-free, and the saturating counter update is already computed.
- Sits between the integer execute/writeback stage and the predictor PHT write ports. This removes the predictor's same-cycle same-address write dropping and decouples execute from PHT write timing.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- ENQ_WIDTH, 2, enqueue lanes (equals INT_ISSUE_WIDTH).
- INDEX_BITS, 9, PHT entry index width.
- HIST_BITS, 2, local-history width; selects 1 of 2^HIST_BITS counters in an entry.
- CTR_BITS, 2, saturating counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enq_valid  in  ENQ_WIDTH  lane i carries a resolved conditional branch
- enq_index  in  ENQ_WIDTH x INDEX_BITS  PHT index of the branch
- enq_hist  in  ENQ_WIDTH x HIST_BITS  history used at prediction time
- enq_ctr  in  ENQ_WIDTH x CTR_BITS  counter value read at prediction time
- enq_taken  in  ENQ_WIDTH  actual direction
- hold  in  1  predictor busy (PHT init); no dequeue while high
- flush  in  1  synchronous clear of all queued entries
- wr_en  out  2  PHT write port enables
- wr_index  out  2 x INDEX_BITS  write addresses
- wr_sel  out  2 x HIST_BITS  counter select within entry
- wr_ctr  out  2 x CTR_BITS  new counter value
- occupancy  out  log2(DEPTH)+1  entries currently held
- almost_full  out  1  occupancy > DEPTH-ENQ_WIDTH
- drop_count  out  16  saturating count of discarded results

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Reset (async):
  - head, tail, occupancy and drop_count clear to 0.
  - wr_en is 0. wr_index, wr_sel and wr_ctr are 0.
  - almost_full is 0.
- Enqueue, same cycle as valid:
  - Valid lanes are compacted in lane order (lane 0 first) and written at tail.
  - If free slots after this cycle's dequeue are fewer than the number of valid lanes, lane 0 is kept before lane 1.
  - Each lane that does not fit increments drop_count, saturating at 16'hFFFF.
- Counter arithmetic, computed at enqueue and stored:
  - taken: new = (ctr == 2^CTR_BITS-1) ? ctr : ctr+1.
  - not taken: new = (ctr == 0) ? 0 : ctr-1.
- Dequeue:
  - Combinational from the registered queue state; wr_* are registered outputs, so writes appear 1 cycle after the entries leave the queue.
  - Port 0 takes the head entry if occupancy ≥ 1 and hold = 0.
  - Port 1 takes head+1 if occupancy ≥ 2, hold = 0, and index[0] differs from the head entry's index[0] (different bank).
  - Otherwise port 1 is idle and head+1 waits for the next cycle.
- Same-index pair never issues in one cycle: same index implies same bank, which the bank rule already serialises.
- Enqueued entries are not dequeuable until the following cycle. Minimum enqueue-to-wr_en latency is 2 cycles.
- Simultaneous enqueue and dequeue: occupancy_next = occupancy + accepted − dequeued. A full queue with dequeue 2 accepts 2 in the same cycle.
- flush:
  - Clears head, tail and occupancy, and suppresses this cycle's enqueue and dequeue.
  - Next-cycle wr_en is 0. drop_count is unchanged.
  - Flushed lanes do not count as drops.
- hold high:
  - wr_en is 0 the next cycle. The queue keeps accepting entries; overflow drops as above.
- Reset mid-operation: all state clears immediately; no partial write is emitted.

Decomposition:
- Shared package (FetchUnitTypes):
  - BrUpdateEntry struct {index, sel, ctr}.
  - BR_UPDATE_QUEUE_DEPTH constant.
  - Saturating-counter increment/decrement function, also reusable by the predictor.
- Natural sub-module: br_update_queue_ram, a DEPTH-entry, 2-write / 2-read register array holding BrUpdateEntry. The top level holds pointers, enqueue compaction, bank arbitration and the drop counter.

Test Plan:
- Single enqueue:
  - Stimulus: lane0 valid, index 5, hist 2, ctr 1, taken=1.
  - Response: 2 cycles later wr_en = 2'b01, wr_index[0] = 5, wr_sel[0] = 2, wr_ctr[0] = 2; occupancy returns to 0.
- Saturation:
  - ctr 3, taken → wr_ctr 3.
  - ctr 0, not taken → wr_ctr 0.
- Bank conflict:
  - Stimulus: both lanes valid in one cycle, indices 4 and 6.
  - Response: wr_en = 01 (index 4), then wr_en = 01 (index 6) next cycle.
  - With indices 4 and 7 instead: wr_en = 11 in a single cycle.
- Overflow with hold:
  - Stimulus: hold = 1, 5 cycles of dual enqueue into DEPTH = 8.
  - Response: occupancy 8; drop_count = 2; almost_full asserted from occupancy 7. On hold release, the queue drains in order.
- flush with valid lanes:
  - Stimulus: assert flush with occupancy 3 and 2 valid lanes.
  - Response: next cycle occupancy 0, wr_en 0, drop_count unchanged.
- Async reset during drain:
  - Stimulus: assert rst mid-cycle while draining.
  - Response: wr_en drops to 0 immediately; occupancy and drop_count read 0.
